// File: rtl/time_date_counter.sv
// Real-time clock/calendar core. Advances HH:MM:SS and YY/MM/DD once per
// prescaler tick, loads sanitised time/date/alarm values on request with a
// one-cycle acknowledge, and pulses ALARM_MATCH when the running time reaches
// the stored alarm time.
module time_date_counter #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [5:0]  MODE,
  input  logic        SETTING,
  input  logic        ALARM_SETTING,
  input  logic        ALARM_ENABLE,
  input  logic [16:0] OUT_TIME,
  input  logic [15:0] OUT_DATE,
  input  logic [16:0] OUT_ALARM_TIME,
  output logic [16:0] IN_TIME,
  output logic [15:0] IN_DATE,
  output logic [16:0] IN_ALARM_TIME,
  output logic        SETTING_OK,
  output logic        ALARM_MATCH
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_e;

  // Days in the given month; February has 29 days when year[1:0] is zero.
  function automatic logic [4:0] days_in_month(input logic [6:0] year, input logic [3:0] month);
    logic [4:0] dim;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

  // Force each time field into its legal range (out-of-range fields become 0).
  function automatic logic [16:0] sanitize_time(input logic [16:0] t);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    h = (t[16:12] > 5'd23) ? 5'd0 : t[16:12];
    m = (t[11:6]  > 6'd59) ? 6'd0 : t[11:6];
    s = (t[5:0]   > 6'd59) ? 6'd0 : t[5:0];
    return {h, m, s};
  endfunction

  // Force each date field into range; the day is clamped against the
  // already-sanitised year and month.
  function automatic logic [15:0] sanitize_date(input logic [15:0] d);
    logic [6:0] y;
    logic [3:0] mo;
    logic [4:0] dy;
    logic [4:0] dim;
    y  = (d[15:9] > 7'd99) ? 7'd0 : d[15:9];
    mo = ((d[8:5] == 4'd0) || (d[8:5] > 4'd12)) ? 4'd1 : d[8:5];
    dim = days_in_month(y, mo);
    if (d[4:0] == 5'd0) begin
      dy = 5'd1;
    end else if (d[4:0] > dim) begin
      dy = dim;
    end else begin
      dy = d[4:0];
    end
    return {y, mo, dy};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    year_q, year_d;
  logic [3:0]    month_q, month_d;
  logic [4:0]    day_q, day_d;
  logic [16:0]   alarm_q, alarm_d;
  logic          upd_q, upd_d;
  logic          match_q, match_d;
  logic          ok_q;
  state_e        state_q;

  logic       halt_s, req_s, load_s, tick_s;
  logic       c_sec_s, c_min_s, c_hour_s, c_day_s, c_mon_s;
  logic [4:0] dim_cur_s;
  logic       unused_mode_s;

  assign unused_mode_s = ^MODE[3:0];
  assign halt_s    = MODE[4] & ~MODE[5];
  assign req_s     = SETTING | ALARM_SETTING;
  assign load_s    = (state_q == S_IDLE) && req_s;
  // A load on the same edge as a tick wins; that tick is discarded.
  assign tick_s    = !halt_s && (presc_q == PRE_LAST) && !load_s;
  assign dim_cur_s = days_in_month(year_q, month_q);
  assign c_sec_s   = (sec_q == 6'd59);
  assign c_min_s   = c_sec_s && (min_q == 6'd59);
  assign c_hour_s  = c_min_s && (hour_q == 5'd23);
  assign c_day_s   = c_hour_s && (day_q == dim_cur_s);
  assign c_mon_s   = c_day_s && (month_q == 4'd12);

  // Prescaler: held at 0 while halted, restarted by a load, wraps after the tick.
  always_comb begin
    presc_d = presc_q;
    if (halt_s || load_s || (presc_q == PRE_LAST)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Time/date next state: sanitised load, else carry chain on tick, else hold.
  always_comb begin
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    if (load_s && SETTING) begin
      {hour_d, min_d, sec_d}    = sanitize_time(OUT_TIME);
      {year_d, month_d, day_d}  = sanitize_date(OUT_DATE);
    end else if (tick_s) begin
      sec_d   = c_sec_s  ? 6'd0 : sec_q + 6'd1;
      min_d   = c_sec_s  ? (c_min_s  ? 6'd0 : min_q + 6'd1)   : min_q;
      hour_d  = c_min_s  ? (c_hour_s ? 5'd0 : hour_q + 5'd1)  : hour_q;
      day_d   = c_hour_s ? (c_day_s  ? 5'd1 : day_q + 5'd1)   : day_q;
      month_d = c_day_s  ? (c_mon_s  ? 4'd1 : month_q + 4'd1) : month_q;
      year_d  = c_mon_s  ? ((year_q == 7'd99) ? 7'd0 : year_q + 7'd1) : year_q;
    end else begin
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      year_d  = year_q;
      month_d = month_q;
      day_d   = day_q;
    end
  end

  // Alarm register load and alarm compare, evaluated the cycle after a tick update.
  always_comb begin
    alarm_d = alarm_q;
    if (load_s && ALARM_SETTING) begin
      alarm_d = sanitize_time(OUT_ALARM_TIME);
    end else begin
      alarm_d = alarm_q;
    end
    upd_d   = tick_s;
    match_d = upd_q && ALARM_ENABLE && !halt_s && ({hour_q, min_q, sec_q} == alarm_q);
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      presc_q <= '0;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      year_q  <= 7'd0;
      month_q <= 4'd1;
      day_q   <= 5'd1;
      alarm_q <= 17'd0;
      upd_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      alarm_q <= alarm_d;
      upd_q   <= upd_d;
      match_q <= match_d;
    end
  end

  // Load handshake FSM: acknowledge once, then wait for both requests to drop.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      ok_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_s) begin
            state_q <= S_ACK;
            ok_q    <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            ok_q    <= 1'b0;
          end
        end
        S_ACK: begin
          state_q <= S_WAIT_LOW;
          ok_q    <= 1'b0;
        end
        S_WAIT_LOW: begin
          ok_q <= 1'b0;
          if (!req_s) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT_LOW;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ok_q    <= 1'b0;
        end
      endcase
    end
  end

  assign IN_TIME       = {hour_q, min_q, sec_q};
  assign IN_DATE       = {year_q, month_q, day_q};
  assign IN_ALARM_TIME = alarm_q;
  assign SETTING_OK    = ok_q;
  assign ALARM_MATCH   = match_q;

endmodule

// File: tb/tb_time_date_counter.sv
// Directed self-checking bench for time_date_counter with a 10-cycle tick.
module tb_time_date_counter;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [5:0]  MODE;
  logic        SETTING;
  logic        ALARM_SETTING;
  logic        ALARM_ENABLE;
  logic [16:0] OUT_TIME;
  logic [15:0] OUT_DATE;
  logic [16:0] OUT_ALARM_TIME;
  logic [16:0] IN_TIME;
  logic [15:0] IN_DATE;
  logic [16:0] IN_ALARM_TIME;
  logic        SETTING_OK;
  logic        ALARM_MATCH;

  int n_checks = 0;
  int n_fail   = 0;

  time_date_counter #(.TICK_DIV(10)) dut (
    .CLK(CLK), .RESETN(RESETN), .MODE(MODE), .SETTING(SETTING),
    .ALARM_SETTING(ALARM_SETTING), .ALARM_ENABLE(ALARM_ENABLE),
    .OUT_TIME(OUT_TIME), .OUT_DATE(OUT_DATE), .OUT_ALARM_TIME(OUT_ALARM_TIME),
    .IN_TIME(IN_TIME), .IN_DATE(IN_DATE), .IN_ALARM_TIME(IN_ALARM_TIME),
    .SETTING_OK(SETTING_OK), .ALARM_MATCH(ALARM_MATCH)
  );

  always #5 CLK = ~CLK;

  function automatic logic [16:0] mk_time(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [15:0] mk_date(input int y, input int m, input int d);
    return {7'(y), 4'(m), 5'(d)};
  endfunction

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present a load request for one edge, then drop it. Returns just after the load edge.
  task automatic apply_load(input logic [16:0] t, input logic [15:0] d, input logic [16:0] a,
                            input logic set, input logic aset);
    step(2);
    OUT_TIME = t; OUT_DATE = d; OUT_ALARM_TIME = a;
    SETTING = set; ALARM_SETTING = aset;
    step(1);
    SETTING = 1'b0; ALARM_SETTING = 1'b0;
  endtask

  task automatic test_reset;
    int ok_seen;
    RESETN = 1'b0; MODE = 6'd0; SETTING = 1'b0; ALARM_SETTING = 1'b0; ALARM_ENABLE = 1'b0;
    OUT_TIME = 17'd0; OUT_DATE = 16'd0; OUT_ALARM_TIME = 17'd0;
    step(3);
    n_checks++; if (IN_TIME !== 17'd0) begin n_fail++; $display("FAIL reset_time: got %h expected %h", IN_TIME, 17'd0); end
    n_checks++; if (IN_DATE !== mk_date(0, 1, 1)) begin n_fail++; $display("FAIL reset_date: got %h expected %h", IN_DATE, mk_date(0, 1, 1)); end
    n_checks++; if ({SETTING_OK, ALARM_MATCH, IN_ALARM_TIME} !== 19'd0) begin n_fail++; $display("FAIL reset_misc: got ok=%b match=%b alarm=%h expected 0", SETTING_OK, ALARM_MATCH, IN_ALARM_TIME); end
    RESETN = 1'b1;
    ok_seen = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (SETTING_OK !== 1'b0) ok_seen++;
    end
    n_checks++; if (ok_seen !== 0) begin n_fail++; $display("FAIL idle_setting_ok: got %0d ack cycles expected 0", ok_seen); end
    n_checks++; if (IN_TIME !== mk_time(0, 0, 2)) begin n_fail++; $display("FAIL idle_time: got %h expected %h", IN_TIME, mk_time(0, 0, 2)); end
    n_checks++; if (IN_DATE !== mk_date(0, 1, 1)) begin n_fail++; $display("FAIL idle_date: got %h expected %h", IN_DATE, mk_date(0, 1, 1)); end
  endtask

  task automatic test_rollover_held_setting;
    int acks;
    OUT_TIME = mk_time(23, 59, 59); OUT_DATE = mk_date(99, 12, 31); SETTING = 1'b1;
    step(1);
    n_checks++; if (SETTING_OK !== 1'b1) begin n_fail++; $display("FAIL load_ack: got %b expected 1", SETTING_OK); end
    n_checks++; if (IN_TIME !== mk_time(23, 59, 59)) begin n_fail++; $display("FAIL load_time: got %h expected %h", IN_TIME, mk_time(23, 59, 59)); end
    n_checks++; if (IN_DATE !== mk_date(99, 12, 31)) begin n_fail++; $display("FAIL load_date: got %h expected %h", IN_DATE, mk_date(99, 12, 31)); end
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (SETTING_OK !== 1'b0) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL held_setting_reack: got %0d extra acks expected 0", acks); end
    SETTING = 1'b0;
    step(4);
    n_checks++; if (IN_TIME !== mk_time(23, 59, 59)) begin n_fail++; $display("FAIL pre_tick_time: got %h expected %h", IN_TIME, mk_time(23, 59, 59)); end
    step(1);
    n_checks++; if (IN_TIME !== 17'd0) begin n_fail++; $display("FAIL rollover_time: got %h expected %h", IN_TIME, 17'd0); end
    n_checks++; if (IN_DATE !== mk_date(0, 1, 1)) begin n_fail++; $display("FAIL rollover_date: got %h expected %h", IN_DATE, mk_date(0, 1, 1)); end
  endtask

  task automatic test_leap_year;
    apply_load(mk_time(23, 59, 59), mk_date(3, 2, 28), 17'd0, 1'b1, 1'b0);
    step(10);
    n_checks++; if (IN_DATE !== mk_date(3, 3, 1)) begin n_fail++; $display("FAIL feb_common: got %h expected %h", IN_DATE, mk_date(3, 3, 1)); end
    n_checks++; if (IN_TIME !== 17'd0) begin n_fail++; $display("FAIL feb_common_time: got %h expected %h", IN_TIME, 17'd0); end
    apply_load(mk_time(23, 59, 59), mk_date(4, 2, 28), 17'd0, 1'b1, 1'b0);
    step(10);
    n_checks++; if (IN_DATE !== mk_date(4, 2, 29)) begin n_fail++; $display("FAIL feb_leap: got %h expected %h", IN_DATE, mk_date(4, 2, 29)); end
  endtask

  task automatic test_sanitize;
    apply_load(17'd0, mk_date(5, 4, 31), 17'd0, 1'b1, 1'b0);
    n_checks++; if (IN_DATE !== mk_date(5, 4, 30)) begin n_fail++; $display("FAIL clamp_day30: got %h expected %h", IN_DATE, mk_date(5, 4, 30)); end
    apply_load(mk_time(25, 10, 5), mk_date(7, 0, 15), 17'd0, 1'b1, 1'b0);
    n_checks++; if (IN_TIME !== mk_time(0, 10, 5)) begin n_fail++; $display("FAIL hour_over: got %h expected %h", IN_TIME, mk_time(0, 10, 5)); end
    n_checks++; if (IN_DATE !== mk_date(7, 1, 15)) begin n_fail++; $display("FAIL month_zero: got %h expected %h", IN_DATE, mk_date(7, 1, 15)); end
    apply_load(mk_time(12, 60, 61), mk_date(120, 2, 30), 17'd0, 1'b1, 1'b0);
    n_checks++; if (IN_TIME !== mk_time(12, 0, 0)) begin n_fail++; $display("FAIL min_sec_over: got %h expected %h", IN_TIME, mk_time(12, 0, 0)); end
    n_checks++; if (IN_DATE !== mk_date(0, 2, 29)) begin n_fail++; $display("FAIL year_over_feb: got %h expected %h", IN_DATE, mk_date(0, 2, 29)); end
    apply_load(mk_time(1, 1, 1), mk_date(1, 13, 0), mk_time(24, 61, 59), 1'b0, 1'b1);
    n_checks++; if (IN_ALARM_TIME !== mk_time(0, 0, 59)) begin n_fail++; $display("FAIL alarm_sanitize: got %h expected %h", IN_ALARM_TIME, mk_time(0, 0, 59)); end
    n_checks++; if (IN_DATE !== mk_date(0, 2, 29)) begin n_fail++; $display("FAIL alarm_only_keeps_date: got %h expected %h", IN_DATE, mk_date(0, 2, 29)); end
    apply_load(mk_time(1, 1, 1), mk_date(1, 13, 0), 17'd0, 1'b1, 1'b0);
    n_checks++; if (IN_DATE !== mk_date(1, 1, 1)) begin n_fail++; $display("FAIL month13_day0: got %h expected %h", IN_DATE, mk_date(1, 1, 1)); end
  endtask

  task automatic test_halt;
    apply_load(mk_time(10, 20, 30), mk_date(1, 1, 1), 17'd0, 1'b1, 1'b0);
    MODE = 6'b010011;
    step(50);
    n_checks++; if (IN_TIME !== mk_time(10, 20, 30)) begin n_fail++; $display("FAIL halt_frozen: got %h expected %h", IN_TIME, mk_time(10, 20, 30)); end
    MODE = 6'd0;
    step(9);
    n_checks++; if (IN_TIME !== mk_time(10, 20, 30)) begin n_fail++; $display("FAIL halt_release_early: got %h expected %h", IN_TIME, mk_time(10, 20, 30)); end
    step(1);
    n_checks++; if (IN_TIME !== mk_time(10, 20, 31)) begin n_fail++; $display("FAIL halt_release_tick: got %h expected %h", IN_TIME, mk_time(10, 20, 31)); end
  endtask

  task automatic test_alarm;
    int pulses, pulse_at, acks;
    logic [16:0] match_time;
    ALARM_ENABLE = 1'b1;
    apply_load(17'd0, mk_date(0, 1, 1), mk_time(0, 0, 3), 1'b1, 1'b1);
    n_checks++; if (SETTING_OK !== 1'b1) begin n_fail++; $display("FAIL dual_load_ack: got %b expected 1", SETTING_OK); end
    n_checks++; if (IN_ALARM_TIME !== mk_time(0, 0, 3)) begin n_fail++; $display("FAIL dual_load_alarm: got %h expected %h", IN_ALARM_TIME, mk_time(0, 0, 3)); end
    n_checks++; if (IN_TIME !== 17'd0) begin n_fail++; $display("FAIL dual_load_time: got %h expected %h", IN_TIME, 17'd0); end
    pulses = 0; pulse_at = -1; acks = 0; match_time = 17'd0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (SETTING_OK !== 1'b0) acks++;
      if (ALARM_MATCH === 1'b1) begin pulses++; pulse_at = k; match_time = IN_TIME; end
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL dual_load_single_ack: got %0d extra acks expected 0", acks); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL alarm_pulse_count: got %0d expected 1", pulses); end
    n_checks++; if (pulse_at !== 31) begin n_fail++; $display("FAIL alarm_pulse_cycle: got %0d expected 31", pulse_at); end
    n_checks++; if (match_time !== mk_time(0, 0, 3)) begin n_fail++; $display("FAIL alarm_pulse_time: got %h expected %h", match_time, mk_time(0, 0, 3)); end
    apply_load(mk_time(0, 0, 3), mk_date(0, 1, 1), mk_time(0, 0, 3), 1'b1, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (ALARM_MATCH === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL alarm_by_load: got %0d pulses expected 0", pulses); end
    ALARM_ENABLE = 1'b0;
    apply_load(17'd0, mk_date(0, 1, 1), mk_time(0, 0, 3), 1'b1, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (ALARM_MATCH === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL alarm_disabled: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_reset_during_ack;
    ALARM_ENABLE = 1'b1;
    apply_load(mk_time(5, 6, 7), mk_date(8, 9, 10), mk_time(1, 2, 3), 1'b1, 1'b1);
    n_checks++; if (SETTING_OK !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack: got %b expected 1", SETTING_OK); end
    #2 RESETN = 1'b0;
    #1;
    n_checks++; if (SETTING_OK !== 1'b0) begin n_fail++; $display("FAIL async_reset_ack: got %b expected 0", SETTING_OK); end
    n_checks++; if (IN_TIME !== 17'd0) begin n_fail++; $display("FAIL async_reset_time: got %h expected %h", IN_TIME, 17'd0); end
    n_checks++; if (IN_DATE !== mk_date(0, 1, 1)) begin n_fail++; $display("FAIL async_reset_date: got %h expected %h", IN_DATE, mk_date(0, 1, 1)); end
    n_checks++; if ({ALARM_MATCH, IN_ALARM_TIME} !== 18'd0) begin n_fail++; $display("FAIL async_reset_alarm: got match=%b alarm=%h expected 0", ALARM_MATCH, IN_ALARM_TIME); end
    step(2);
    RESETN = 1'b1;
    step(10);
    n_checks++; if (IN_TIME !== mk_time(0, 0, 1)) begin n_fail++; $display("FAIL post_reset_count: got %h expected %h", IN_TIME, mk_time(0, 0, 1)); end
    n_checks++; if (SETTING_OK !== 1'b0) begin n_fail++; $display("FAIL post_reset_ack: got %b expected 0", SETTING_OK); end
  endtask

  initial begin
    test_reset();
    test_rollover_held_setting();
    test_leap_year();
    test_sanitize();
    test_halt();
    test_alarm();
    test_reset_during_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
